fir_frame_ctrl: RTL and testbench

Sequencer that owns the FIR datapath between the sample source and the FFT stage. On a start command it resets the FIR, streams source samples into it without gaps, captures a programmed number of 16-sample filtered frames into an output FIFO, tags frame boundaries for the FFT, then tears the FIR down and reports completion and error status.

---
 rtl/fir_frame_ctrl_if.sv | 35 +++
 rtl/fir_frame_ctrl.sv | 227 ++++++++++++++++++++++
 tb/tb_fir_frame_ctrl.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_frame_ctrl_if.sv
// fir_frame_ctrl_if
// Bundles the three streams that fir_frame_ctrl sits between:
//   source  : in_valid / in_data  -> controller, in_ready back
//   FIR     : fir_rst / fir_data_valid / fir_data -> FIR, fir_valid / fir_d back
//   FFT     : out_valid / out_data / out_last -> FFT, out_ready back
// modport master : the controller side (fir_frame_ctrl)
// modport slave  : the surrounding system (source, FIR, FFT)
interface fir_frame_ctrl_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;

    logic        fir_rst;
    logic        fir_data_valid;
    logic [15:0] fir_data;
    logic        fir_valid;
    logic [15:0] fir_d;

    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ready;

    modport master (
        input  in_valid, in_data, fir_valid, fir_d, out_ready,
        output in_ready, fir_rst, fir_data_valid, fir_data,
               out_valid, out_data, out_last
    );

    modport slave (
        output in_valid, in_data, fir_valid, fir_d, out_ready,
        input  in_ready, fir_rst, fir_data_valid, fir_data,
               out_valid, out_data, out_last
    );
endinterface

// File: rtl/fir_frame_ctrl.sv
// fir_frame_ctrl
// Sequencer owning the FIR datapath between the sample source and the FFT.
// A start command resets the FIR for one cycle, streams source samples into
// it without gaps, captures cfg_frames x FRAME_LEN filtered words into a
// show-ahead output FIFO (last word of each frame tagged), then tears down
// and pulses done once the FIFO has drained.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle run request (honoured only when idle)
//   cfg_frames      frames to produce, latched on accepted start
//   busy            high whenever not idle
//   done            one-cycle pulse when returning to idle
//   err_udf         sticky: source underran while the FIR was running
//   err_ovf         sticky: FIR word dropped on a full FIFO
//   stat_in         samples accepted since start     (FIR_FRAME_CTRL_STATS_EN)
//   stat_drop       dropped words, saturating at 255 (FIR_FRAME_CTRL_STATS_EN)
//   bus             fir_frame_ctrl_if.master (source, FIR and FFT streams)
//
// Optional feature macro: FIR_FRAME_CTRL_STATS_EN adds the stat_* counters.
module fir_frame_ctrl #(
    parameter int FRAME_LEN = 16,
    parameter int DEPTH     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       cfg_frames,
    output logic             busy,
    output logic             done,
    output logic             err_udf,
    output logic             err_ovf,
`ifdef FIR_FRAME_CTRL_STATS_EN
    output logic [15:0]      stat_in,
    output logic [7:0]       stat_drop,
`endif
    fir_frame_ctrl_if.master bus
);

    localparam int FL_W  = $clog2(FRAME_LEN);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FRST  = 2'd1,
        S_RUN   = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [7:0]  r_frames;
    logic [11:0] r_cap_cnt;
    logic        r_done;
    logic        r_err_udf;
    logic        r_err_ovf;
    logic        r_fir_data_valid;
    logic [15:0] r_fir_data;

    // FIFO storage: {last, data}
    logic [16:0]      r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic        w_start_ok;
    logic        w_fdv_next;
    logic        w_done_next;
    logic        w_in_run;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_cap;
    logic        w_push;
    logic        w_drop;
    logic        w_last;
    logic        w_final;
    logic [11:0] w_cap_total;

    assign w_in_run    = (r_state == S_RUN);
    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_pop       = !w_empty && bus.out_ready;
    assign w_cap       = w_in_run && bus.fir_valid;
    // A full FIFO still takes the word when the FFT frees a slot this cycle.
    assign w_push      = w_cap && (!w_full || w_pop);
    assign w_drop      = w_cap && w_full && !w_pop;
    assign w_cap_total = 12'(r_frames) << FL_W;
    // The capture counter advances on dropped words too, so frame tagging
    // stays aligned to the FIR output stream rather than to FIFO contents.
    assign w_last      = (r_cap_cnt[FL_W-1:0] == FL_W'(FRAME_LEN - 1));
    assign w_final     = w_cap && (r_cap_cnt == w_cap_total - 12'd1);

    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_fdv_next   = 1'b0;
        w_done_next  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_start_ok   = 1'b1;
                    // Zero frames skips the FIR entirely; the empty FIFO
                    // lets DRAIN finish on its first cycle.
                    w_state_next = (cfg_frames == 8'd0) ? S_DRAIN : S_FRST;
                end
            end
            S_FRST: begin
                w_state_next = S_RUN;
            end
            S_RUN: begin
                if (!bus.in_valid || w_final) begin
                    w_state_next = S_DRAIN;
                end else begin
                    // Only forward samples while the run continues; the one
                    // taken on the exit cycle is discarded by teardown.
                    w_fdv_next = 1'b1;
                end
            end
            S_DRAIN: begin
                if (w_empty) begin
                    w_state_next = S_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_frames         <= 8'd0;
            r_cap_cnt        <= 12'd0;
            r_done           <= 1'b0;
            r_err_udf        <= 1'b0;
            r_err_ovf        <= 1'b0;
            r_fir_data_valid <= 1'b0;
            r_fir_data       <= 16'd0;
            r_wr_ptr         <= '0;
            r_rd_ptr         <= '0;
            r_count          <= '0;
        end else begin
            r_state          <= w_state_next;
            r_done           <= w_done_next;
            r_fir_data_valid <= w_fdv_next;
            if (w_in_run && bus.in_valid) begin
                r_fir_data <= bus.in_data;
            end
            if (w_start_ok) begin
                r_frames  <= cfg_frames;
                r_cap_cnt <= 12'd0;
                r_err_udf <= 1'b0;
                r_err_ovf <= 1'b0;
            end else begin
                if (w_cap) begin
                    r_cap_cnt <= r_cap_cnt + 12'd1;
                end
                if (w_in_run && !bus.in_valid) begin
                    r_err_udf <= 1'b1;
                end
                if (w_drop) begin
                    r_err_ovf <= 1'b1;
                end
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage has no reset; an empty FIFO masks whatever it holds.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_last, bus.fir_d};
        end
    end

`ifdef FIR_FRAME_CTRL_STATS_EN
    logic [15:0] r_stat_in;
    logic [7:0]  r_stat_drop;

    always_ff @(posedge clk) begin
        if (rst || w_start_ok) begin
            r_stat_in   <= 16'd0;
            r_stat_drop <= 8'd0;
        end else begin
            if (w_in_run && bus.in_valid) begin
                r_stat_in <= r_stat_in + 16'd1;
            end
            if (w_drop && (r_stat_drop != 8'hff)) begin
                r_stat_drop <= r_stat_drop + 8'd1;
            end
        end
    end

    assign stat_in   = r_stat_in;
    assign stat_drop = r_stat_drop;
`endif

    assign busy               = (r_state != S_IDLE);
    assign done               = r_done;
    assign err_udf            = r_err_udf;
    assign err_ovf            = r_err_ovf;
    assign bus.in_ready       = w_in_run;
    assign bus.fir_rst        = rst || (r_state == S_FRST);
    assign bus.fir_data_valid = r_fir_data_valid;
    assign bus.fir_data       = r_fir_data;
    // Show-ahead read straight from storage so a word captured at one edge
    // is presented during the very next cycle.
    assign bus.out_valid      = !w_empty;
    assign bus.out_data       = w_empty ? 16'd0 : r_mem[r_rd_ptr][15:0];
    assign bus.out_last       = !w_empty && r_mem[r_rd_ptr][16];

endmodule

// File: tb/tb_fir_frame_ctrl.sv
module tb_fir_frame_ctrl;
    localparam int FRAME_LEN = 16;
    localparam int DEPTH     = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] cfg_frames;
    logic       busy, done, err_udf, err_ovf;
`ifdef FIR_FRAME_CTRL_STATS_EN
    logic [15:0] stat_in;
    logic [7:0]  stat_drop;
`endif

    fir_frame_ctrl_if bus();

    always #5 clk = ~clk;

    fir_frame_ctrl #(.FRAME_LEN(FRAME_LEN), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .cfg_frames(cfg_frames),
        .busy(busy),
        .done(done),
        .err_udf(err_udf),
        .err_ovf(err_ovf),
`ifdef FIR_FRAME_CTRL_STATS_EN
        .stat_in(stat_in),
        .stat_drop(stat_drop),
`endif
        .bus(bus.master)
    );

    // Behavioural FIR: 4-tap moving sum, output valid (sticky) once four
    // samples have entered since the last fir_rst.
    logic [15:0] tap0, tap1, tap2;
    int          fir_n;
    always @(posedge clk) begin
        if (bus.fir_rst) begin
            tap0 <= 16'd0; tap1 <= 16'd0; tap2 <= 16'd0;
            fir_n <= 0;
            bus.fir_valid <= 1'b0;
            bus.fir_d <= 16'd0;
        end else if (bus.fir_data_valid) begin
            tap0 <= bus.fir_data; tap1 <= tap0; tap2 <= tap1;
            fir_n <= fir_n + 1;
            bus.fir_d <= bus.fir_data + tap0 + tap1 + tap2;
            if (fir_n >= 3) bus.fir_valid <= 1'b1;
        end
    end

    int          errors = 0;
    int          checks = 0;
    int          done_cnt;
    bit          rdy_rand = 1'b0;
    logic [15:0] smp_q[$];
    logic [16:0] rx_q[$];

    // Frame word i is the FIR sum over accepted samples i..i+3; the last
    // word of each frame carries the tag.
    function automatic logic [16:0] exp_word(input int i);
        logic [15:0] s;
        s = smp_q[i] + smp_q[i+1] + smp_q[i+2] + smp_q[i+3];
        return {((i % FRAME_LEN) == FRAME_LEN - 1), s};
    endfunction

    // Records the transfers that the coming posedge performs, then advances
    // to the next negedge and refreshes the source sample.
    task automatic step();
        if (bus.in_valid && bus.in_ready) smp_q.push_back(bus.in_data);
        if (bus.out_valid && bus.out_ready) begin
            rx_q.push_back({bus.out_last, bus.out_data});
            $display("  word %0d data=%h last=%b", rx_q.size() - 1, bus.out_data, bus.out_last);
        end
        if (done) done_cnt++;
        @(negedge clk);
        bus.in_data = 16'($urandom);
        if (rdy_rand) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_log();
        smp_q.delete();
        rx_q.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [7:0] n);
        cfg_frames = n;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_frames = 8'($urandom);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_done: no done pulse within %0d cycles, required one", tag, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; cfg_frames = 8'd0;
        bus.in_valid = 1'b0; bus.in_data = 16'd0; bus.out_ready = 1'b0;
        @(negedge clk);
        step(); step();
        checks++;
        if ({busy, done, err_udf, err_ovf, bus.in_ready, bus.fir_data_valid} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b required 000000",
                     {busy, done, err_udf, err_ovf, bus.in_ready, bus.fir_data_valid});
        end
        checks++;
        if (bus.fir_rst !== 1'b1) begin
            errors++; $display("FAIL reset_fir_rst: got %b required 1", bus.fir_rst);
        end
        checks++;
        if ({bus.out_valid, bus.out_last, bus.out_data, bus.fir_data} !== 34'd0) begin
            errors++;
            $display("FAIL reset_data: got ov=%b ol=%b od=%h fd=%h required all zero",
                     bus.out_valid, bus.out_last, bus.out_data, bus.fir_data);
        end
`ifdef FIR_FRAME_CTRL_STATS_EN
        checks++;
        if (stat_in !== 16'd0 || stat_drop !== 8'd0) begin
            errors++; $display("FAIL reset_stats: got in=%0d drop=%0d required 0/0", stat_in, stat_drop);
        end
`endif
        rst = 1'b0;
        step();
        checks++;
        if (bus.fir_rst !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: got fir_rst=%b busy=%b required 0/0", bus.fir_rst, busy);
        end
        $display("test_reset complete");
    endtask

    task automatic test_frames2();
        clear_log();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        do_start(8'd2);
        checks++;
        if (bus.fir_rst !== 1'b1 || busy !== 1'b1 || bus.fir_data_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL f2_frst: got fir_rst=%b busy=%b fdv=%b rdy=%b required 1/1/0/0",
                     bus.fir_rst, busy, bus.fir_data_valid, bus.in_ready);
        end
        step();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.fir_rst !== 1'b0 || bus.fir_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL f2_run: got rdy=%b fir_rst=%b fdv=%b required 1/0/0",
                     bus.in_ready, bus.fir_rst, bus.fir_data_valid);
        end
        step();
        checks++;
        if (bus.fir_data_valid !== 1'b1) begin
            errors++; $display("FAIL f2_fdv: got %b required 1", bus.fir_data_valid);
        end
        wait_done(200, "f2");
        checks++;
        if (rx_q.size() != 32) begin
            errors++; $display("FAIL f2_count: got %0d words required 32", rx_q.size());
        end
        for (int i = 0; i < rx_q.size(); i++) begin
            checks++;
            if (i + 3 >= smp_q.size() || rx_q[i] !== exp_word(i)) begin
                errors++; $display("FAIL f2_word%0d: got %h required %h", i, rx_q[i], exp_word(i));
            end
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err_udf !== 1'b0 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL f2_end: got busy=%b done=%b udf=%b ovf=%b required 0/0/0/0", busy, done, err_udf, err_ovf);
        end
`ifdef FIR_FRAME_CTRL_STATS_EN
        checks++;
        if (stat_in !== 16'(smp_q.size())) begin
            errors++; $display("FAIL f2_stat_in: got %0d required %0d", stat_in, smp_q.size());
        end
`endif
        repeat (3) step();
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL f2_done_cnt: got %0d pulses required 1", done_cnt);
        end
        $display("test_frames2 complete");
    endtask

    task automatic test_hold();
        clear_log();
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        do_start(8'd1);
        repeat (30) step();
        checks++;
        if (bus.out_valid !== 1'b1 || busy !== 1'b1 || done_cnt != 0 || err_ovf !== 1'b0) begin
            errors++;
            $display("FAIL hold_wait: got ov=%b busy=%b dones=%0d ovf=%b required 1/1/0/0",
                     bus.out_valid, busy, done_cnt, err_ovf);
        end
        bus.out_ready = 1'b1;
        for (int n = 0; n < 40 && rx_q.size() < 16; n++) step();
        checks++;
        if (rx_q.size() != 16 || done !== 1'b0 || bus.out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_empty: got words=%0d done=%b ov=%b busy=%b required 16/0/0/1",
                     rx_q.size(), done, bus.out_valid, busy);
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL hold_done: got done=%b busy=%b required 1/0", done, busy);
        end
        step();
        checks++;
        if (done !== 1'b0 || done_cnt != 1) begin
            errors++; $display("FAIL hold_pulse: got done=%b pulses=%0d required 0/1", done, done_cnt);
        end
        for (int i = 0; i < rx_q.size(); i++) begin
            checks++;
            if (i + 3 >= smp_q.size() || rx_q[i] !== exp_word(i)) begin
                errors++; $display("FAIL hold_word%0d: got %h required %h", i, rx_q[i], exp_word(i));
            end
        end
        $display("test_hold complete");
    endtask

    task automatic test_underrun();
        int gap_at = $urandom_range(8, 30);
        clear_log();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        do_start(8'd2);
        for (int n = 0; n < 100 && smp_q.size() < gap_at; n++) step();
        checks++;
        if (smp_q.size() != gap_at || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL udf_reach: got samples=%0d rdy=%b required %0d/1", smp_q.size(), bus.in_ready, gap_at);
        end
        bus.in_valid = 1'b0;
        step();
        bus.in_valid = 1'b1;
        checks++;
        if (err_udf !== 1'b1 || bus.fir_data_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL udf_flag: got udf=%b fdv=%b rdy=%b required 1/0/0", err_udf, bus.fir_data_valid, bus.in_ready);
        end
        wait_done(100, "udf");
        checks++;
        if (rx_q.size() != gap_at - 4) begin
            errors++; $display("FAIL udf_count: got %0d words required %0d", rx_q.size(), gap_at - 4);
        end
        for (int i = 0; i < rx_q.size(); i++) begin
            checks++;
            if (i + 3 >= smp_q.size() || rx_q[i] !== exp_word(i)) begin
                errors++; $display("FAIL udf_word%0d: got %h required %h", i, rx_q[i], exp_word(i));
            end
        end
        checks++;
        if (err_udf !== 1'b1 || err_ovf !== 1'b0) begin
            errors++; $display("FAIL udf_sticky: got udf=%b ovf=%b required 1/0", err_udf, err_ovf);
        end
        $display("test_underrun complete gap_at=%0d", gap_at);
    endtask

    task automatic test_overflow();
        clear_log();
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        do_start(8'd3);
        checks++;
        if (err_udf !== 1'b0 || err_ovf !== 1'b0) begin
            errors++; $display("FAIL ovf_clear: got udf=%b ovf=%b required 0/0", err_udf, err_ovf);
        end
        repeat (60) step();
        checks++;
        if (err_ovf !== 1'b1 || busy !== 1'b1 || bus.out_valid !== 1'b1) begin
            errors++; $display("FAIL ovf_flag: got ovf=%b busy=%b ov=%b required 1/1/1", err_ovf, busy, bus.out_valid);
        end
`ifdef FIR_FRAME_CTRL_STATS_EN
        checks++;
        if (stat_drop !== 8'd16) begin
            errors++; $display("FAIL ovf_stat_drop: got %0d required 16", stat_drop);
        end
`endif
        bus.out_ready = 1'b1;
        wait_done(100, "ovf");
        checks++;
        if (rx_q.size() != DEPTH) begin
            errors++; $display("FAIL ovf_count: got %0d words required %0d", rx_q.size(), DEPTH);
        end
        for (int i = 0; i < rx_q.size(); i++) begin
            checks++;
            if (i + 3 >= smp_q.size() || rx_q[i] !== exp_word(i)) begin
                errors++; $display("FAIL ovf_word%0d: got %h required %h", i, rx_q[i], exp_word(i));
            end
        end
        checks++;
        if (err_ovf !== 1'b1 || err_udf !== 1'b0) begin
            errors++; $display("FAIL ovf_sticky: got ovf=%b udf=%b required 1/0", err_ovf, err_udf);
        end
        $display("test_overflow complete");
    endtask

    task automatic test_zero_frames();
        clear_log();
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        do_start(8'd0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || bus.fir_rst !== 1'b0 || bus.fir_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_c1: got busy=%b done=%b fir_rst=%b fdv=%b required 1/0/0/0",
                     busy, done, bus.fir_rst, bus.fir_data_valid);
        end
        step();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.fir_rst !== 1'b0 || bus.fir_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_c2: got done=%b busy=%b fir_rst=%b fdv=%b required 1/0/0/0",
                     done, busy, bus.fir_rst, bus.fir_data_valid);
        end
        step();
        checks++;
        if (done !== 1'b0 || rx_q.size() != 0 || smp_q.size() != 0) begin
            errors++;
            $display("FAIL zero_end: got done=%b words=%0d samples=%0d required 0/0/0", done, rx_q.size(), smp_q.size());
        end
        $display("test_zero_frames complete");
    endtask

    task automatic test_rst_midrun();
        clear_log();
        bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        do_start(8'd3);
        repeat (16) step();
        checks++;
        if (bus.out_valid !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rstm_pre: got ov=%b busy=%b required 1/1", bus.out_valid, busy);
        end
        rst = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.fir_rst !== 1'b1 ||
            bus.in_ready !== 1'b0 || bus.fir_data_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstm_state: got ov=%b busy=%b fir_rst=%b rdy=%b fdv=%b required 0/0/1/0/0",
                     bus.out_valid, busy, bus.fir_rst, bus.in_ready, bus.fir_data_valid);
        end
        rst = 1'b0;
        step();
        checks++;
        if (bus.fir_rst !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++; $display("FAIL rstm_release: got fir_rst=%b ov=%b required 0/0", bus.fir_rst, bus.out_valid);
        end
        clear_log();
        bus.out_ready = 1'b1;
        do_start(8'd1);
        wait_done(100, "rstm");
        checks++;
        if (rx_q.size() != FRAME_LEN) begin
            errors++; $display("FAIL rstm_count: got %0d words required %0d", rx_q.size(), FRAME_LEN);
        end
        for (int i = 0; i < rx_q.size(); i++) begin
            checks++;
            if (i + 3 >= smp_q.size() || rx_q[i] !== exp_word(i)) begin
                errors++; $display("FAIL rstm_word%0d: got %h required %h", i, rx_q[i], exp_word(i));
            end
        end
        $display("test_rst_midrun complete");
    endtask

    task automatic test_backpressure();
        for (int r = 0; r < 2; r++) begin
            clear_log();
            bus.in_valid = 1'b1; bus.out_ready = 1'b1;
            rdy_rand = 1'b1;
            do_start(8'd2);
            wait_done(400, "bp");
            rdy_rand = 1'b0;
            bus.out_ready = 1'b1;
            checks++;
            if (rx_q.size() != 32 || err_ovf !== 1'b0) begin
                errors++; $display("FAIL bp_count: got %0d words ovf=%b required 32/0", rx_q.size(), err_ovf);
            end
            for (int i = 0; i < rx_q.size(); i++) begin
                checks++;
                if (i + 3 >= smp_q.size() || rx_q[i] !== exp_word(i)) begin
                    errors++; $display("FAIL bp_word%0d: got %h required %h", i, rx_q[i], exp_word(i));
                end
            end
            $display("test_backpressure round %0d complete", r);
        end
    endtask

    initial begin
        test_reset();
        test_frames2();
        test_hold();
        test_underrun();
        test_overflow();
        test_zero_frames();
        test_rst_midrun();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
